// File: rtl/wac_adc_pkg.sv
// Shared definitions for the AD7476-style SPI ADC driver.
package wac_adc_pkg;

  localparam int unsigned FRAME_BITS_DFLT = 16;
  localparam int unsigned DATA_BITS_DFLT  = 12;
  localparam int unsigned LEAD_BITS       = FRAME_BITS_DFLT - DATA_BITS_DFLT;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StDone,
    StQuiet
  } adcState_t;

endpackage

// File: rtl/wac_sclk_gen.sv
// SCLK divider for the ADC frame. Counters describe the current SHIFT cycle; the
// outputs tell the owner what SCLK does next and when to sample or end the frame.
module wac_sclk_gen #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclkNext,
  output logic sampleStb,
  output logic frameEnd
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 1);
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);

  logic [DivW-1:0] divCnt;
  logic            phaseHigh;
  logic [BitW-1:0] bitCnt;
  logic            divLast;

  assign divLast = (divCnt == DivW'(CLK_DIV - 1));

  // Half-period and bit counters; held at the start of a low phase while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      divCnt    <= '0;
      phaseHigh <= 1'b0;
      bitCnt    <= '0;
    end else if (divLast) begin
      divCnt    <= '0;
      phaseHigh <= !phaseHigh;
      if (phaseHigh) bitCnt <= bitCnt + 1'b1;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Level for the next cycle, sample point at the end of low phase, frame end at last high.
  always_comb begin
    sclkNext  = divLast ? !phaseHigh : phaseHigh;
    sampleStb = en && !phaseHigh && divLast;
    frameEnd  = en && phaseHigh && divLast && (bitCnt == BitW'(FRAME_BITS - 1));
  end

endmodule

// File: rtl/wac_adc_spi.sv
// Serial driver for the 12-bit SPI ADC: single-shot or continuous conversions,
// registered SPI pins, result register with a one-cycle ready strobe.
module wac_adc_spi
  import wac_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned QUIET_CYCLES = 8,
  parameter int unsigned FRAME_BITS   = FRAME_BITS_DFLT,
  parameter int unsigned DATA_BITS    = DATA_BITS_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 controlEn,
  input  logic                 modeAdc,
  input  logic                 adcSdata,
  output logic                 adcCs,
  output logic                 adcSclk,
  output logic [DATA_BITS-1:0] datoAdc,
  output logic                 readyAdc,
  output logic                 adcBusy,
  output logic                 leadErr
);

  localparam int unsigned LeadBits = FRAME_BITS - DATA_BITS;
  localparam int unsigned CntMax   = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  adcState_t             state;
  logic [CntW-1:0]       cnt;
  logic [FRAME_BITS-1:0] shiftReg;
  logic                  sclkNext;
  logic                  sampleStb;
  logic                  frameEnd;

  wac_sclk_gen #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS)
  ) u_sclk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state == StShift),
    .sclkNext (sclkNext),
    .sampleStb(sampleStb),
    .frameEnd (frameEnd)
  );

  // Frame sequencer; every pin is written on the transition so outputs stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      cnt      <= '0;
      shiftReg <= '0;
      adcCs    <= 1'b1;
      adcSclk  <= 1'b1;
      datoAdc  <= '0;
      readyAdc <= 1'b0;
      adcBusy  <= 1'b0;
      leadErr  <= 1'b0;
    end else begin
      readyAdc <= 1'b0;
      unique case (state)
        StIdle: begin
          if (controlEn) begin
            state   <= StCsSetup;
            cnt     <= '0;
            adcCs   <= 1'b0;
            adcBusy <= 1'b1;
          end
        end
        StCsSetup: begin
          if (cnt == CntW'(CLK_DIV - 1)) begin
            state   <= StShift;
            cnt     <= '0;
            adcSclk <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StShift: begin
          adcSclk <= sclkNext;
          if (sampleStb) shiftReg <= {shiftReg[FRAME_BITS-2:0], adcSdata};
          if (frameEnd) begin
            state    <= StDone;
            adcCs    <= 1'b1;
            adcSclk  <= 1'b1;
            readyAdc <= 1'b1;
            datoAdc  <= shiftReg[DATA_BITS-1:0];
            if (|shiftReg[FRAME_BITS-1 -: LeadBits]) leadErr <= 1'b1;
          end
        end
        StDone: begin
          state <= StQuiet;
          cnt   <= '0;
        end
        StQuiet: begin
          if (cnt == CntW'(QUIET_CYCLES - 1)) begin
            cnt <= '0;
            // Mode is only looked at here, so a drop mid-frame still finishes that frame.
            if (modeAdc) begin
              state <= StCsSetup;
              adcCs <= 1'b0;
            end else begin
              state   <= StIdle;
              adcBusy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wac_adc_spi.sv
// Bench for wac_adc_spi: default build plus a CLK_DIV=1 build, each with an ADC model.
module tb_wac_adc_spi;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, controlEn, modeAdc, adcSdata;
  logic        adcCs, adcSclk, readyAdc, adcBusy, leadErr;
  logic [11:0] datoAdc;

  logic        controlEn1, modeAdc1, adcSdata1;
  logic        adcCs1, adcSclk1, readyAdc1, adcBusy1, leadErr1;
  logic [11:0] datoAdc1;

  wac_adc_spi u_dut (
    .clk      (clk),
    .rst      (rst),
    .controlEn(controlEn),
    .modeAdc  (modeAdc),
    .adcSdata (adcSdata),
    .adcCs    (adcCs),
    .adcSclk  (adcSclk),
    .datoAdc  (datoAdc),
    .readyAdc (readyAdc),
    .adcBusy  (adcBusy),
    .leadErr  (leadErr)
  );

  wac_adc_spi #(.CLK_DIV(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .controlEn(controlEn1),
    .modeAdc  (modeAdc1),
    .adcSdata (adcSdata1),
    .adcCs    (adcCs1),
    .adcSclk  (adcSclk1),
    .datoAdc  (datoAdc1),
    .readyAdc (readyAdc1),
    .adcBusy  (adcBusy1),
    .leadErr  (leadErr1)
  );

  int errors = 0;
  int checks = 0;

  // ADC model: frame latched while CS is high, next bit presented after each SCLK rise.
  logic [15:0] frameWord = '0, curWord = '0;
  int bitIdx = 0, csLowCyc = 0, edgesLast = 0, csLowLast = 0;
  logic prevSclk = 1'b1, prevCs = 1'b1;
  always @(negedge clk) begin
    if (adcCs !== 1'b0) begin
      if (!prevCs) begin
        edgesLast = bitIdx;
        csLowLast = csLowCyc;
      end
      bitIdx   = 0;
      csLowCyc = 0;
      curWord  = frameWord;
    end else begin
      csLowCyc++;
      if (adcSclk && !prevSclk) bitIdx++;
    end
    prevSclk = adcSclk;
    prevCs   = (adcCs !== 1'b0);
  end
  assign adcSdata = (adcCs === 1'b0 && bitIdx < 16) ? curWord[15-bitIdx] : 1'b0;

  logic [15:0] frameWord1 = '0, curWord1 = '0;
  int bitIdx1 = 0, csLowCyc1 = 0, edgesLast1 = 0, csLowLast1 = 0;
  logic prevSclk1 = 1'b1, prevCs1 = 1'b1;
  always @(negedge clk) begin
    if (adcCs1 !== 1'b0) begin
      if (!prevCs1) begin
        edgesLast1 = bitIdx1;
        csLowLast1 = csLowCyc1;
      end
      bitIdx1   = 0;
      csLowCyc1 = 0;
      curWord1  = frameWord1;
    end else begin
      csLowCyc1++;
      if (adcSclk1 && !prevSclk1) bitIdx1++;
    end
    prevSclk1 = adcSclk1;
    prevCs1   = (adcCs1 !== 1'b0);
  end
  assign adcSdata1 = (adcCs1 === 1'b0 && bitIdx1 < 16) ? curWord1[15-bitIdx1] : 1'b0;

  // Scoreboard of expected {sample, strobe cycle} for the default build.
  typedef struct {
    logic [11:0] dato;
    int          cycle;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int readyCnt = 0;
  always @(negedge clk) begin
    if (readyAdc === 1'b1) begin
      readyCnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: cycle=%0d dato=%h, required no strobe", cyc, datoAdc);
      end else begin
        e = sbq.pop_front();
        if (datoAdc !== e.dato || cyc != e.cycle) begin
          errors++;
          $display("FAIL ready_sample: dato=%h cycle=%0d, required dato=%h cycle=%0d",
                   datoAdc, cyc, e.dato, e.cycle);
        end
      end
    end
  end

  typedef struct {
    logic [15:0] frame;
    logic [11:0] dato;
    logic        lead;
  } vec_t;
  vec_t vec[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitReady(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (readyAdc === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: no readyAdc within %0d cycles", maxc);
    end
  endtask

  // Called just after a negedge; returns the cycle in which controlEn was high.
  task automatic pulseStart(output int n);
    n = cyc;
    controlEn = 1'b1;
    @(negedge clk);
    controlEn = 1'b0;
  endtask

  int n, r, r2, cnt0, k;

  initial begin
    rst = 1'b1; controlEn = 1'b0; modeAdc = 1'b0;
    controlEn1 = 1'b0; modeAdc1 = 1'b0;
    vec[0] = '{16'h0ABC, 12'hABC, 1'b0};
    vec[1] = '{16'h0FFF, 12'hFFF, 1'b0};
    vec[2] = '{16'h0000, 12'h000, 1'b0};
    vec[3] = '{16'h0A5A, 12'hA5A, 1'b0};
    vec[4] = '{16'h8005, 12'h005, 1'b1};
    vec[5] = '{16'h0123, 12'h123, 1'b1};
    tick(3);
    rst = 1'b0;
    tick(2);

    check("rst_cs", adcCs, 1);
    check("rst_sclk", adcSclk, 1);
    check("rst_dato", datoAdc, 0);
    check("rst_ready", readyAdc, 0);
    check("rst_busy", adcBusy, 0);
    check("rst_lead", leadErr, 0);

    // Single-shot frames, including sticky lead-bit error.
    for (int i = 0; i < 6; i++) begin
      frameWord = vec[i].frame;
      sbq.push_back('{vec[i].dato, cyc + 67});
      pulseStart(n);
      check("cs_low_n1", adcCs, 0);
      check("busy_n1", adcBusy, 1);
      waitReady(100, r);
      check("lead_err", leadErr, vec[i].lead);
      tick(1);
      check("ready_one_cycle", readyAdc, 0);
      tick(7);
      check("busy_in_quiet", adcBusy, 1);
      tick(1);
      check("idle_after_quiet", adcBusy, 0);
      check("sclk_rises", edgesLast, 16);
      check("cs_low_cycles", csLowLast, 66);
      check("dato_held", datoAdc, vec[i].dato);
    end

    // Continuous mode; mode drops during the third frame.
    tick(3);
    frameWord = 16'h0001;
    modeAdc = 1'b1;
    sbq.push_back('{12'h001, cyc + 67});
    sbq.push_back('{12'h002, cyc + 142});
    sbq.push_back('{12'h003, cyc + 217});
    cnt0 = readyCnt;
    pulseStart(n);
    waitReady(100, r);
    frameWord = 16'h0002;
    waitReady(100, r2);
    frameWord = 16'h0003;
    k = 0;
    while (adcCs !== 1'b0 && k < 20) begin
      tick(1);
      k++;
    end
    check("cont_next_frame", adcCs, 0);
    modeAdc = 1'b0;
    waitReady(100, r);
    tick(9);
    check("cont_idle", adcBusy, 0);
    tick(150);
    check("cont_strobes", readyCnt - cnt0, 3);
    check("cont_sb_empty", sbq.size(), 0);

    // Requests during SHIFT and QUIET are ignored.
    frameWord = 16'h0321;
    sbq.push_back('{12'h321, cyc + 67});
    cnt0 = readyCnt;
    pulseStart(n);
    tick(29);
    controlEn = 1'b1;
    tick(1);
    controlEn = 1'b0;
    tick(39);
    controlEn = 1'b1;
    tick(1);
    controlEn = 1'b0;
    tick(5);
    check("ign_idle", adcBusy, 0);
    tick(150);
    check("ign_strobes", readyCnt - cnt0, 1);

    // Reset in the 20th SHIFT cycle aborts the frame and clears leadErr.
    frameWord = 16'h0777;
    cnt0 = readyCnt;
    pulseStart(n);
    tick(21);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_cs", adcCs, 1);
    check("mid_rst_sclk", adcSclk, 1);
    check("mid_rst_dato", datoAdc, 0);
    check("mid_rst_busy", adcBusy, 0);
    check("mid_rst_lead", leadErr, 0);
    tick(150);
    check("mid_rst_no_ready", readyCnt - cnt0, 0);
    frameWord = 16'h0BEE;
    sbq.push_back('{12'hBEE, cyc + 67});
    pulseStart(n);
    waitReady(100, r);
    check("post_rst_lead", leadErr, 0);
    tick(10);

    // CLK_DIV=1 build.
    frameWord1 = 16'h0C3A;
    n = cyc;
    controlEn1 = 1'b1;
    tick(1);
    controlEn1 = 1'b0;
    r = -1;
    for (int i = 0; i < 60; i++) begin
      if (readyAdc1 === 1'b1) begin
        r = cyc;
        break;
      end
      tick(1);
    end
    check("div1_ready_cycle", r, n + 34);
    check("div1_dato", datoAdc1, 12'hC3A);
    tick(2);
    check("div1_sclk_rises", edgesLast1, 16);
    check("div1_cs_low_cycles", csLowLast1, 33);
    check("div1_lead", leadErr1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
